gpio_irq: RTL and testbench
===========================

Name: gpio_irq

Overview:
- Parametrised successor to the board GPIO port: WIDTH bidirectional pins with a per-pin direction register.
- Adds atomic set/clear of output bits, input synchronisation, per-pin edge detection with selectable polarity, and a maskable level interrupt.
- Sits on the 8-bit CPU peripheral bus (cs/rw/AD/DI/DO) beside the other board peripherals. Drives one irq line to the interrupt controller.

Parameters:
- WIDTH, 16, pin count; multiple of 8, range 8..32; NB = WIDTH/8 byte lanes.
- SYNC_STAGES, 2, input synchroniser depth; minimum 2.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- AD  in  5  AD[4:2] register select, AD[1:0] byte lane.
- DI  in  8  write data.
- DO  out  8  read data, combinational from AD.
- rw  in  1  1 = read, 0 = write.
- cs  in  1  chip select; write occurs on posedge clk when cs && ~rw.
- gpio  inout  WIDTH  pins; driven from the output latch where DIR=1, else Z.
- irq  out  1  registered, active-high: |(IFLAG & IE).

Behaviour:
- Byte lanes: lane k maps to register bits [8*(NB-1-k)+7 : 8*(NB-1-k)], so lane 0 is the MS byte.
  - Lanes k >= NB read 0x00; writes to them are ignored.
- Register map (AD[4:2]):
  - 0 DATA: read gives sync_in where DIR=0 and out latch where DIR=1. Write loads the out latch unmasked.
  - 1 DIR: 1 = output.
  - 2 OUTSET: write-1 sets out bits; reads 0.
  - 3 OUTCLR: write-1 clears out bits; reads 0.
  - 4 IE: interrupt enable per pin.
  - 5 POL: 1 = rising edge, 0 = falling edge.
  - 6 IFLAG: read returns flags; write-1 clears flags.
  - 7 reserved: reads 0, writes ignored (see optional feature).
- Reset (async): out latch, DIR, IE, POL, IFLAG, synchroniser, prev register and irq all 0. All pins Z; DO follows the map with zeroed state.
- Synchroniser: each pin passes through SYNC_STAGES flops to give sync_in. The prev register holds the last sync_in.
- Edge detect: edge[i] = ~DIR[i] && (POL[i] ? (sync_in & ~prev) : (~sync_in & prev)). Pins configured as outputs never flag.
- IFLAG[i] is set on the posedge where edge[i]=1, independent of IE. Flags stay set until cleared.
- Latency: a pin transition stable before edge 1 is visible in DATA after edge SYNC_STAGES. IFLAG sets after edge SYNC_STAGES+1; irq rises after edge SYNC_STAGES+2.
- Simultaneous edge and write-1-clear on the same bit in the same cycle: the set wins, so the flag stays 1.
- Clearing IE does not clear IFLAG. irq drops the cycle after IE or IFLAG goes to 0.
- DIR change 1→0: prev is updated every cycle regardless of DIR, so no stale edge is reported from the output period.
- Reset asserted mid-operation clears everything immediately; no bus write is taken while rst=1.

Optional Feature:
- Macro GPIO_ANYEDGE_EN.
- Defined: register 7 is ANY (read/write, reset 0). ANY[i]=1 flags both edges on pin i and overrides POL[i].
- Undefined: register 7 reads 0, writes are ignored, and no ANY storage exists.

Decomposition:
- Package gpio_pkg:
  - Register index constants REG_DATA..REG_ANY (3-bit).
  - Function lane_sel(lane, NB) returning the bit offset.
  - Constant MAX_LANES=4.
- Sub-module gpio_sync: a SYNC_STAGES-deep per-bit synchroniser, parametrised by WIDTH, with async reset to 0. Instantiated once.

Test Plan:
- Reset, then read all registers with WIDTH=16 → every read 0x00; gpio all Z; irq=0.
- Write DIR lanes 0xFF,0x00, then DATA 0xA5,0x3C; external drive low byte 0x5A → pins[15:8]=0xA5. DATA read gives lane0=0xA5, lane1=0x5A. Lanes 2 and 3 read 0x00.
- With out=0x00F0, write OUTSET lane1 0x0F, then OUTCLR lane1 0x80 → DATA readback of the output bits = 0x007F.
- POL[3]=1, IE[3]=1, DIR=0; drive pin3 0→1 before edge 1 → IFLAG lane1=0x08 after edge 3; irq=1 after edge 4. Write IFLAG lane1 0x08 → irq=0 one cycle later.
- Pin3 rising edge detected in the same cycle as a write-1-clear of IFLAG bit 3 → IFLAG bit 3 stays 1. A falling edge with POL[3]=1 → no flag.
- GPIO_ANYEDGE_EN defined, ANY[0]=1: pin0 toggles 0→1→0 → the flag is set on both edges (clear in between). Undefined: writing reg 7 then reading it → 0x00.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared constants and helpers for the gpio_irq peripheral.
//   MAX_LANES  : byte lanes addressable through AD[1:0]
//   LANE_BITS  : width of the lane field of AD
//   REG_*      : register select codes carried on AD[4:2]
//   lane_sel() : bit offset of a byte lane inside a WIDTH-bit register,
//                lane 0 being the most significant byte
package gpio_pkg;

    localparam int MAX_LANES = 4;
    localparam int LANE_BITS = $clog2(MAX_LANES);

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_DIR    = 3'd1;
    localparam logic [2:0] REG_OUTSET = 3'd2;
    localparam logic [2:0] REG_OUTCLR = 3'd3;
    localparam logic [2:0] REG_IE     = 3'd4;
    localparam logic [2:0] REG_POL    = 3'd5;
    localparam logic [2:0] REG_IFLAG  = 3'd6;
    localparam logic [2:0] REG_ANY    = 3'd7;

    // Only meaningful for lane < nb; callers gate out-of-range lanes.
    function automatic int lane_sel(input logic [LANE_BITS-1:0] lane, input int nb);
        return 8 * (nb - 1 - int'(lane));
    endfunction

endpackage

// File: rtl/gpio_irq_if.sv
// gpio_irq_if
// 8-bit CPU peripheral bus as seen by one board peripheral.
//   cs : chip select
//   rw : 1 = read, 0 = write
//   AD : AD[4:2] register select, AD[1:0] byte lane
//   DI : write data from the CPU
//   DO : read data back to the CPU (combinational in the peripheral)
// master modport is the CPU side, slave modport the peripheral side.
interface gpio_irq_if;

    logic       cs;
    logic       rw;
    logic [4:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;

    modport master (output cs, output rw, output AD, output DI, input DO);
    modport slave  (input cs, input rw, input AD, input DI, output DO);

endinterface

// File: rtl/gpio_sync.sv
// gpio_sync
// Per-bit multi-flop synchroniser for asynchronous pin inputs.
//   clk : system clock
//   rst : asynchronous active-high reset, clears every stage
//   d   : raw asynchronous inputs
//   q   : synchronised outputs, SYNC_STAGES clocks behind d
module gpio_sync #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // stage[0] is the metastability catcher, stage[SYNC_STAGES-1] the clean output
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_irq.sv
// gpio_irq
// WIDTH-pin bidirectional GPIO port with atomic set/clear, synchronised
// inputs, per-pin edge detection and a maskable level interrupt.
//   clk  : system clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : 8-bit peripheral bus (cs/rw/AD/DI/DO), slave side
//   gpio : pins, driven from the output latch where DIR=1, else Z
//   irq  : registered interrupt request, |(IFLAG & IE)
// Optional feature: define GPIO_ANYEDGE_EN to make register 7 the ANY
// register (per-pin both-edge detection overriding POL).
module gpio_irq
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    gpio_irq_if.slave        bus,
    inout  wire  [WIDTH-1:0] gpio,
    output logic             irq
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] ie_q;
    logic [WIDTH-1:0] pol_q;
    logic [WIDTH-1:0] iflag_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] lane_data;
    logic [WIDTH-1:0] flag_clr;
    logic [WIDTH-1:0] read_word;
    logic [2:0]           reg_sel;
    logic [LANE_BITS-1:0] lane;
    logic                 lane_ok;
    logic                 wr_en;
    int                   lane_off;

`ifdef GPIO_ANYEDGE_EN
    logic [WIDTH-1:0] any_q;
`endif

    assign reg_sel = bus.AD[4:2];
    assign lane    = bus.AD[LANE_BITS-1:0];

    // Lanes beyond the implemented width behave as an empty hole in the map.
    always_comb begin
        lane_ok  = int'(lane) < NB;
        lane_off = 0;
        if (lane_ok) begin
            lane_off = lane_sel(lane, NB);
        end
    end

    assign wr_en     = bus.cs & ~bus.rw & lane_ok;
    assign lane_data = WIDTH'(bus.DI) << lane_off;
    assign flag_clr  = (wr_en && reg_sel == REG_IFLAG) ? lane_data : '0;

    // Each pin is driven only while configured as an output.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gpio),
        .q   (sync_in)
    );

    assign rise = sync_in & ~prev_q;
    assign fall = ~sync_in & prev_q;

    // Output pins never flag; prev keeps tracking them so a later switch to
    // input does not report an edge left over from the output period.
`ifdef GPIO_ANYEDGE_EN
    assign edge_hit = ~dir_q & ((any_q & (rise | fall)) |
                                (~any_q & ((pol_q & rise) | (~pol_q & fall))));
`else
    assign edge_hit = ~dir_q & ((pol_q & rise) | (~pol_q & fall));
`endif

    // Register state, flags and the interrupt line. A new edge is OR-ed in
    // after the write-1-clear so a coincident set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            dir_q   <= '0;
            ie_q    <= '0;
            pol_q   <= '0;
            iflag_q <= '0;
            prev_q  <= '0;
            irq     <= 1'b0;
`ifdef GPIO_ANYEDGE_EN
            any_q   <= '0;
`endif
        end else begin
            prev_q  <= sync_in;
            irq     <= |(iflag_q & ie_q);
            iflag_q <= (iflag_q & ~flag_clr) | edge_hit;
            if (wr_en) begin
                case (reg_sel)
                    REG_DATA:   out_q <= (out_q & ~(WIDTH'(8'hFF) << lane_off)) | lane_data;
                    REG_DIR:    dir_q <= (dir_q & ~(WIDTH'(8'hFF) << lane_off)) | lane_data;
                    REG_OUTSET: out_q <= out_q | lane_data;
                    REG_OUTCLR: out_q <= out_q & ~lane_data;
                    REG_IE:     ie_q  <= (ie_q & ~(WIDTH'(8'hFF) << lane_off)) | lane_data;
                    REG_POL:    pol_q <= (pol_q & ~(WIDTH'(8'hFF) << lane_off)) | lane_data;
`ifdef GPIO_ANYEDGE_EN
                    REG_ANY:    any_q <= (any_q & ~(WIDTH'(8'hFF) << lane_off)) | lane_data;
`endif
                    default: ;
                endcase
            end
        end
    end

    // Full-width read value; the lane byte is picked out afterwards.
    always_comb begin
        read_word = '0;
        case (reg_sel)
            REG_DATA:  read_word = (sync_in & ~dir_q) | (out_q & dir_q);
            REG_DIR:   read_word = dir_q;
            REG_IE:    read_word = ie_q;
            REG_POL:   read_word = pol_q;
            REG_IFLAG: read_word = iflag_q;
`ifdef GPIO_ANYEDGE_EN
            REG_ANY:   read_word = any_q;
            REG_OUTSET, REG_OUTCLR: read_word = '0;
`else
            REG_OUTSET, REG_OUTCLR, REG_ANY: read_word = '0;
`endif
            default:   read_word = '0;
        endcase
    end

    assign bus.DO = lane_ok ? 8'(read_word >> lane_off) : 8'h00;

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq
// Self-checking bench for gpio_irq (WIDTH=16, SYNC_STAGES=2). A behavioural
// model keeps the register file as plain vectors and the pin history as a
// queue; the DUT is compared against it on directed and random traffic.
// Honours GPIO_ANYEDGE_EN the same way the design does.
module tb_gpio_irq;

    localparam int WIDTH       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int NB          = WIDTH / 8;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    wire  [WIDTH-1:0] gpio;
    logic [WIDTH-1:0] ext_drv;

    always #5 clk = ~clk;

    gpio_irq_if bus_if ();

    gpio_irq #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .gpio (gpio),
        .irq  (irq)
    );

    // Reference model state
    logic [WIDTH-1:0] m_out, m_dir, m_ie, m_pol, m_any, m_flag;
    logic             m_irq;
    logic [WIDTH-1:0] hist [$];
    int total_checks = 0;
    int bad_checks   = 0;

    // The outside world drives every pin the port is not driving.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ext
        assign gpio[i] = m_dir[i] ? 1'bz : ext_drv[i];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] place(input int lane, input logic [7:0] d);
        return WIDTH'(d) << (8 * (NB - 1 - lane));
    endfunction

    task automatic model_clear();
        m_out = '0; m_dir = '0; m_ie = '0; m_pol = '0; m_any = '0; m_flag = '0;
        m_irq = 1'b0;
        hist.delete();
        for (int i = 0; i <= SYNC_STAGES; i++) hist.push_back('0);
    endtask

    // One clock edge of the model. hist[k] is the pin value sampled k+1
    // edges ago, so the synchronised view is hist[SYNC_STAGES-1] and its
    // previous value hist[SYNC_STAGES].
    task automatic model_step();
        logic [WIDTH-1:0] pin, cur, old, edges, w, m, clr;
        int sel, lane;
        if (rst) begin
            model_clear();
            return;
        end
        pin   = (m_dir & m_out) | (~m_dir & ext_drv);
        cur   = hist[SYNC_STAGES-1];
        old   = hist[SYNC_STAGES];
        edges = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!m_dir[i] && cur[i] != old[i]) begin
                if (m_any[i] || (m_pol[i] == cur[i])) edges[i] = 1'b1;
            end
        end
        m_irq = |(m_flag & m_ie);
        sel   = int'(bus_if.AD[4:2]);
        lane  = int'(bus_if.AD[1:0]);
        clr   = '0;
        w     = '0;
        m     = '0;
        if (bus_if.cs && !bus_if.rw && lane < NB) begin
            w = place(lane, bus_if.DI);
            m = place(lane, 8'hFF);
            if (sel == 6) clr = w;
        end
        m_flag = (m_flag & ~clr) | edges;
        hist.push_front(pin);
        void'(hist.pop_back());
        if (m != '0) begin
            case (sel)
                0: m_out = (m_out & ~m) | w;
                1: m_dir = (m_dir & ~m) | w;
                2: m_out = m_out | w;
                3: m_out = m_out & ~w;
                4: m_ie  = (m_ie & ~m) | w;
                5: m_pol = (m_pol & ~m) | w;
`ifdef GPIO_ANYEDGE_EN
                7: m_any = (m_any & ~m) | w;
`endif
                default: ;
            endcase
        end
    endtask

    function automatic logic [7:0] model_read(input int sel, input int lane);
        logic [WIDTH-1:0] word;
        if (lane >= NB) return 8'h00;
        case (sel)
            0: word = (m_dir & m_out) | (~m_dir & hist[SYNC_STAGES-1]);
            1: word = m_dir;
            4: word = m_ie;
            5: word = m_pol;
            6: word = m_flag;
`ifdef GPIO_ANYEDGE_EN
            7: word = m_any;
`endif
            default: word = '0;
        endcase
        return 8'(word >> (8 * (NB - 1 - lane)));
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Bus write: set up at the falling edge, taken on the next rising edge.
    task automatic applyStimulus(input int sel, input int lane, input logic [7:0] data);
        bus_if.cs = 1'b1;
        bus_if.rw = 1'b0;
        bus_if.AD = {3'(sel), 2'(lane)};
        bus_if.DI = data;
        tick();
        bus_if.cs = 1'b0;
        bus_if.rw = 1'b1;
    endtask

    task automatic readReg(input int sel, input int lane, output logic [7:0] data);
        bus_if.cs = 1'b1;
        bus_if.rw = 1'b1;
        bus_if.AD = {3'(sel), 2'(lane)};
        #1;
        data = bus_if.DO;
        bus_if.cs = 1'b0;
    endtask

    task automatic checkRead(input string tag, input int sel, input int lane);
        logic [7:0] d;
        readReg(sel, lane, d);
        checkOutput(tag, 32'(d), 32'(model_read(sel, lane)));
    endtask

    task automatic checkLit(input string tag, input int sel, input int lane, input logic [7:0] exp);
        logic [7:0] d;
        readReg(sel, lane, d);
        checkOutput(tag, 32'(d), 32'(exp));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] exp_any;
        int sel, lane, op;
        rst       = 1'b1;
        bus_if.cs = 1'b0;
        bus_if.rw = 1'b1;
        bus_if.AD = '0;
        bus_if.DI = '0;
        ext_drv   = '0;
        model_clear();
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state: every register and lane reads zero, no interrupt.
        for (int s = 0; s < 8; s++)
            for (int l = 0; l < 4; l++)
                checkLit($sformatf("rst_r%0d_l%0d", s, l), s, l, 8'h00);
        checkOutput("rst_irq", 32'(irq), 32'd0);

        // Pins are released after reset: an external pattern reads back.
        ext_drv = 16'hC3A5;
        repeat (SYNC_STAGES) tick();
        checkLit("undriven_l0", 0, 0, 8'hC3);
        checkLit("undriven_l1", 0, 1, 8'hA5);
        ext_drv = '0;
        repeat (4) tick();

        // Mixed direction: high byte output, low byte input.
        applyStimulus(1, 0, 8'hFF);
        applyStimulus(1, 1, 8'h00);
        applyStimulus(0, 0, 8'hA5);
        applyStimulus(0, 1, 8'h3C);
        ext_drv = 16'h005A;
        repeat (SYNC_STAGES + 1) tick();
        checkOutput("pins_hi", 32'(gpio[15:8]), 32'hA5);
        checkLit("mix_l0", 0, 0, 8'hA5);
        checkLit("mix_l1", 0, 1, 8'h5A);
        checkLit("mix_l2", 0, 2, 8'h00);
        checkLit("mix_l3", 0, 3, 8'h00);
        checkRead("mix_dir0", 1, 0);

        // Atomic set/clear on the output latch.
        applyStimulus(1, 1, 8'hFF);
        applyStimulus(0, 0, 8'h00);
        applyStimulus(0, 1, 8'hF0);
        applyStimulus(2, 1, 8'h0F);
        applyStimulus(3, 1, 8'h80);
        checkLit("setclr_l0", 0, 0, 8'h00);
        checkLit("setclr_l1", 0, 1, 8'h7F);
        checkOutput("setclr_pins", 32'(gpio), 32'h007F);
        checkLit("outset_rd0", 2, 1, 8'h00);

        // Rising edge on pin 3: latency of flag and interrupt, then clear.
        ext_drv = '0;
        applyStimulus(1, 0, 8'h00);
        applyStimulus(1, 1, 8'h00);
        repeat (5) tick();
        applyStimulus(6, 0, 8'hFF);
        applyStimulus(6, 1, 8'hFF);
        applyStimulus(5, 1, 8'h08);
        applyStimulus(4, 1, 8'h08);
        checkLit("pre_flag", 6, 1, 8'h00);
        ext_drv[3] = 1'b1;
        tick();
        tick();
        checkLit("flag_e2", 6, 1, 8'h00);
        tick();
        checkLit("flag_e3", 6, 1, 8'h08);
        checkOutput("irq_e3", 32'(irq), 32'd0);
        tick();
        checkOutput("irq_e4", 32'(irq), 32'd1);
        applyStimulus(6, 1, 8'h08);
        checkLit("flag_clr", 6, 1, 8'h00);
        checkOutput("irq_hold", 32'(irq), 32'd1);
        tick();
        checkOutput("irq_drop", 32'(irq), 32'd0);

        // Falling edge with rising polarity does not flag.
        ext_drv[3] = 1'b0;
        repeat (4) tick();
        checkLit("fall_noflag", 6, 1, 8'h00);

        // Edge and write-1-clear on the same edge: the set wins.
        ext_drv[3] = 1'b1;
        tick();
        tick();
        applyStimulus(6, 1, 8'h08);
        checkLit("set_wins", 6, 1, 8'h08);
        tick();
        checkOutput("set_wins_irq", 32'(irq), 32'd1);

        // Register 7: ANY when the feature is built in, a hole otherwise.
        applyStimulus(6, 1, 8'hFF);
        applyStimulus(7, 1, 8'h01);
`ifdef GPIO_ANYEDGE_EN
        exp_any = 8'h01;
`else
        exp_any = 8'h00;
`endif
        checkLit("reg7_rd", 7, 1, exp_any);
        ext_drv[0] = 1'b1;
        repeat (4) tick();
        checkLit("any_rise", 6, 1, exp_any);
        applyStimulus(6, 1, 8'h01);
        ext_drv[0] = 1'b0;
        repeat (4) tick();
        checkLit("any_fall", 6, 1, 8'h01);
        checkRead("any_model", 6, 1);

        // Random traffic against the model, with one reset mid-stream.
        for (int it = 0; it < 400; it++) begin
            op = $urandom_range(0, 9);
            if (op < 4) begin
                sel  = $urandom_range(0, 7);
                lane = $urandom_range(0, 3);
                applyStimulus(sel, lane, 8'($urandom));
            end else if (op < 7) begin
                ext_drv = WIDTH'($urandom);
                tick();
            end else begin
                tick();
            end
            sel  = $urandom_range(0, 7);
            lane = $urandom_range(0, 3);
            checkRead("rand_rd", sel, lane);
            checkOutput("rand_irq", 32'(irq), 32'(m_irq));
            checkOutput("rand_pins", 32'(gpio & m_dir), 32'(m_out & m_dir));
            if (it == 200) begin
                bus_if.cs = 1'b1;
                bus_if.rw = 1'b0;
                bus_if.AD = {3'd1, 2'd0};
                bus_if.DI = 8'hFF;
                #2;
                rst = 1'b1;
                model_clear();
                #1;
                checkOutput("midrst_irq", 32'(irq), 32'd0);
                tick();
                bus_if.cs = 1'b0;
                bus_if.rw = 1'b1;
                rst = 1'b0;
                checkLit("midrst_nowr", 1, 0, 8'h00);
                checkLit("midrst_flag", 6, 1, 8'h00);
            end
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
